// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated word RAM answering data-side loads and stores
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        AdrError,
  output logic [15:0] StoreCount
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic store_q, store_d;
  logic err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] count_q, count_d;
  logic [31:0] ram [DEPTH_WORDS];
  logic adr_bad;
  assign adr_bad = (DataAdr[1:0] != 2'b00) || (DataAdr >= LIMIT);
  assign ReadData = rdata_q;
  assign MemReady = state_q == S_RESP;
  assign AdrError = (state_q == S_RESP) && err_q;
  assign StoreCount = count_q;
  // Transaction sequencing, request latching, store counting and load data capture on RESP entry
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    store_d = store_q;
    err_d = err_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    count_d = count_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (MemRead || MemWrite) begin
        store_d = MemWrite;
        err_d = adr_bad;
        idx_d = DataAdr[AW+1:2];
        wdata_d = WriteData;
        cnt_d = WS_INIT;
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
      end
      S_RESP: begin
        state_d = S_IDLE;
        count_d = (store_q && !err_q && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP && state_q != S_RESP)
      rdata_d = err_d ? 32'd0 : (store_d ? rdata_q : ram[idx_d]);
  end
  // Control and data registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      store_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      store_q <= store_d;
      err_q <= err_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end
  // Store commit at the edge that ends RESP; RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && store_q && !err_q) ram[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed checks of two responder instances against a transaction model
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int WS0 = 1;
  localparam int WS1 = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic mr [2];
  logic mw [2];
  logic [31:0] adr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic rdy [2];
  logic err [2];
  logic [15:0] cnt [2];
  int checks = 0;
  int failures = 0;
  int force_gen = 0;
  int force_seen = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .reset(rst_n), .MemRead(mr[0]), .MemWrite(mw[0]), .DataAdr(adr[0]),
    .WriteData(wd[0]), .ReadData(rd[0]), .MemReady(rdy[0]), .AdrError(err[0]), .StoreCount(cnt[0]));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .reset(rst_n), .MemRead(mr[1]), .MemWrite(mw[1]), .DataAdr(adr[1]),
    .WriteData(wd[1]), .ReadData(rd[1]), .MemReady(rdy[1]), .AdrError(err[1]), .StoreCount(cnt[1]));

  logic [31:0] m_mem [2][DEPTH];
  bit m_pend [2];
  int m_left [2];
  bit m_store [2];
  bit m_err [2];
  int m_idx [2];
  logic [31:0] m_wd [2];
  bit e_rdy [2];
  bit e_err [2];
  bit e_chk [2];
  logic [31:0] e_rd [2];
  logic [15:0] e_cnt [2];

  // Transaction-level reference: accept when free, respond after the wait states, commit one edge later
  always @(posedge clk) begin
    bit go;
    for (int k = 0; k < 2; k++) begin
      go = 0;
      if (!rst_n) begin
        m_pend[k] = 0; e_rdy[k] = 0; e_err[k] = 0; e_chk[k] = 0; e_rd[k] = 0; e_cnt[k] = 0;
      end else begin
        if (k == 1 && force_gen != force_seen) begin
          e_cnt[1] = 16'hFFFD;
          force_seen = force_gen;
        end
        if (e_rdy[k]) begin
          if (m_store[k] && !m_err[k]) begin
            m_mem[k][m_idx[k]] = m_wd[k];
            if (e_cnt[k] != 16'hFFFF) e_cnt[k] = e_cnt[k] + 16'd1;
          end
          e_rdy[k] = 0; e_err[k] = 0; e_chk[k] = 0; m_pend[k] = 0;
        end else if (m_pend[k]) begin
          m_left[k] = m_left[k] - 1;
          go = (m_left[k] == 0);
        end else if (mr[k] || mw[k]) begin
          m_store[k] = mw[k];
          m_err[k] = (adr[k] % 4 != 0) || (adr[k] >= 4 * DEPTH);
          m_idx[k] = int'((adr[k] / 4) % DEPTH);
          m_wd[k] = wd[k];
          m_pend[k] = 1;
          m_left[k] = (k == 0) ? WS0 : WS1;
          go = (m_left[k] == 0);
        end
        if (go) begin
          e_rdy[k] = 1;
          e_err[k] = m_err[k];
          e_chk[k] = !m_store[k] || m_err[k];
          if (e_chk[k]) e_rd[k] = m_err[k] ? 32'd0 : m_mem[k][m_idx[k]];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit tamper, output logic [31:0] rdv, output logic ev, output int lat);
    @(negedge clk);
    mr[k] = r; mw[k] = w; adr[k] = a; wd[k] = d; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (tamper && lat == 1) begin wd[k] = 32'd0; adr[k] = ~a; end
    end while (!rdy[k] && lat < 40);
    rdv = rd[k]; ev = err[k];
    mr[k] = 0; mw[k] = 0;
    chk($sformatf("latency%0d", k), 32'(lat), 32'((k == 0 ? WS0 : WS1) + 1));
  endtask

  initial begin
    logic [31:0] v;
    logic e;
    int lat;
    int pulses;
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin mr[k] = 0; mw[k] = 0; adr[k] = 0; wd[k] = 0; end
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("MemReady%0d", k), 32'(rdy[k]), 32'(e_rdy[k]));
          chk($sformatf("AdrError%0d", k), 32'(err[k]), 32'(e_err[k]));
          chk($sformatf("StoreCount%0d", k), 32'(cnt[k]), 32'(e_cnt[k]));
          if (!rst_n || (e_rdy[k] && e_chk[k])) chk($sformatf("ReadData%0d", k), rd[k], e_rd[k]);
        end
      end
    join_none
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(rdy[0]), 32'd0);
    chk("reset_count", 32'(cnt[0]), 32'd0);
    chk("reset_rdata", rd[1], 32'd0);
    rst_n = 1;
    txn(0, 0, 1, 32'h8, 32'h4, 0, v, e, lat);
    chk("t1_store_err", 32'(e), 32'd0);
    @(negedge clk);
    chk("t1_count", 32'(cnt[0]), 32'd1);
    txn(0, 1, 0, 32'h8, 32'h0, 0, v, e, lat);
    chk("t1_load", v, 32'h4);
    for (int w = 0; w < DEPTH; w++)
      for (int k = 0; k < 2; k++) txn(k, 0, 1, 32'(w * 4), $urandom, 0, v, e, lat);
    txn(0, 0, 1, 32'h4, 32'hA5A5A5A5, 0, v, e, lat);
    txn(0, 1, 0, 32'h6, 32'h0, 0, v, e, lat);
    chk("t2_load_err", 32'(e), 32'd1);
    chk("t2_load_rdata", v, 32'd0);
    txn(0, 0, 1, 32'h6, 32'h0, 0, v, e, lat);
    chk("t2_store_err", 32'(e), 32'd1);
    txn(0, 1, 0, 32'h4, 32'h0, 0, v, e, lat);
    chk("t2_word_kept", v, 32'hA5A5A5A5);
    txn(0, 0, 1, 32'h0, 32'h12345678, 0, v, e, lat);
    txn(0, 0, 1, 32'h100, 32'h0, 0, v, e, lat);
    chk("t3_oor_err", 32'(e), 32'd1);
    txn(0, 1, 0, 32'h0, 32'h0, 0, v, e, lat);
    chk("t3_word_kept", v, 32'h12345678);
    txn(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, v, e, lat);
    txn(0, 1, 0, 32'h10, 32'h0, 0, v, e, lat);
    chk("t4_both_is_store", v, 32'hDEADBEEF);
    txn(0, 0, 1, 32'h20, 32'h11111111, 0, v, e, lat);
    @(negedge clk);
    mw[0] = 1; adr[0] = 32'h20; wd[0] = 32'hCAFE0001;
    @(negedge clk);
    wd[0] = 32'd0;
    #1 rst_n = 0; mw[0] = 0;
    @(negedge clk);
    chk("t5_no_ready", 32'(rdy[0]), 32'd0);
    chk("t5_count_cleared", 32'(cnt[0]), 32'd0);
    #1 rst_n = 1;
    txn(0, 1, 0, 32'h20, 32'h0, 0, v, e, lat);
    chk("t5_word_kept", v, 32'h11111111);
    txn(0, 0, 1, 32'h20, 32'hCAFE0002, 1, v, e, lat);
    txn(0, 1, 0, 32'h20, 32'h0, 0, v, e, lat);
    chk("t5_latched_data", v, 32'hCAFE0002);
    @(negedge clk);
    mr[1] = 1; adr[1] = 32'h8; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy[1]) pulses++;
    end
    mr[1] = 0;
    chk("t6_pulses", 32'(pulses), 32'd5);
    @(negedge clk);
    force dut1.count_q = 16'hFFFD;
    force_gen++;
    #1 release dut1.count_q;
    for (int i = 0; i < 4; i++) begin
      txn(1, 0, 1, 32'(i * 4), $urandom, 0, v, e, lat);
      @(negedge clk);
      chk("t6_saturate", 32'(cnt[1]), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end
    for (int i = 0; i < 300; i++) begin
      int k;
      int cls;
      logic [31:0] a;
      k = int'($urandom_range(1, 0));
      cls = int'($urandom_range(7, 0));
      a = (cls < 5) ? 32'($urandom_range(DEPTH - 1, 0) * 4) :
          (cls == 5) ? 32'($urandom_range(4 * DEPTH - 1, 0) | 1) :
          (cls == 6) ? 32'(4 * DEPTH) + 32'($urandom_range(255, 0) * 4) : ($urandom | 32'h8000_0000) & ~32'd3;
      case ($urandom_range(3, 0))
        0: txn(k, 1, 1, a, $urandom, bit'($urandom_range(1, 0)), v, e, lat);
        1, 2: txn(k, 1, 0, a, $urandom, 0, v, e, lat);
        default: txn(k, 0, 1, a, $urandom, bit'($urandom_range(1, 0)), v, e, lat);
      endcase
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
